// File: rtl/spi_pkg.sv
// ----------------------------------------------------------------------------
// spi_pkg
//   Shared types and constants for the SPI master.
//   - state_t     : controller FSM state encoding
//   - MODE0..MODE3: SPI mode constants, encoded as {cpol, cpha}
// ----------------------------------------------------------------------------
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_XFER,
        ST_HOLD,
        ST_DONE
    } state_t;

    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

endpackage

// File: rtl/spi_sclk_gen.sv
// ----------------------------------------------------------------------------
// spi_sclk_gen
//   Half-period timer and SCLK level generator.
//   Ports:
//     clk, rst   : system clock, synchronous active-high reset
//     en         : timer runs while high, held at zero otherwise
//     toggle_en  : SCLK toggles on each tick while high
//     load       : preset SCLK to load_lvl and clear the edge parity
//     load_lvl   : idle level loaded by 'load'
//     div        : half-period is div+1 clk cycles
//     tick       : last cycle of the current half-period
//     sclk_lvl   : current SCLK level
//     odd_edge   : the edge produced by the current tick is odd (1st, 3rd..)
// ----------------------------------------------------------------------------
module spi_sclk_gen #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             toggle_en,
    input  logic             load,
    input  logic             load_lvl,
    input  logic [DIV_W-1:0] div,
    output logic             tick,
    output logic             sclk_lvl,
    output logic             odd_edge
);

    logic [DIV_W-1:0] cnt;
    logic             edge_par;   // parity of edges already produced

    assign tick     = en && (cnt == div);
    assign odd_edge = !edge_par;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_lvl <= 1'b0;
            edge_par <= 1'b0;
        end else if (load) begin
            sclk_lvl <= load_lvl;
            edge_par <= 1'b0;
        end else if (tick && toggle_en) begin
            sclk_lvl <= !sclk_lvl;
            edge_par <= !edge_par;
        end
    end

endmodule

// File: rtl/spi_master_gen2.sv
// ----------------------------------------------------------------------------
// spi_master_gen2
//   Single-word SPI master, all four modes, selectable bit order, runtime
//   clock divider and one-hot active-low slave select.
//   Ports:
//     clk, rst          : system clock, synchronous active-high reset
//     start             : one-cycle request, honoured only when idle
//     cpol, cpha        : SPI mode, latched at start (cpol also drives idle SCLK)
//     lsb_first         : bit order for both directions, latched at start
//     clk_div           : SCLK half-period = clk_div+1 clk cycles, latched
//     ss_sel            : index of the slave to select, latched
//     tx_data           : word to send, latched
//     clr_ntx           : clears the completed-transfer counter
//     miso              : serial data in
//     rx_data           : last fully received word
//     busy, done        : transfer in progress / one-cycle completion pulse
//     ntx               : completed transfers, modulo 256
//     sclk, mosi, ss_n  : SPI bus
// ----------------------------------------------------------------------------
module spi_master_gen2
    import spi_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int N_SS   = 4,
    parameter  int DIV_W  = 8,
    localparam int SS_W   = (N_SS > 1) ? $clog2(N_SS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              lsb_first,
    input  logic [DIV_W-1:0]  clk_div,
    input  logic [SS_W-1:0]   ss_sel,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              clr_ntx,
    input  logic              miso,
    output logic [DATA_W-1:0] rx_data,
    output logic              busy,
    output logic              done,
    output logic [7:0]        ntx,
    output logic              sclk,
    output logic              mosi,
    output logic [N_SS-1:0]   ss_n
);

    localparam int             EW        = $clog2(2 * DATA_W + 1);
    localparam logic [EW-1:0]  LAST_EDGE = EW'(2 * DATA_W - 1);

    state_t            state_q, state_d;
    logic              cpol_q, cpha_q, lsb_q;
    logic [DIV_W-1:0]  div_q;
    logic [SS_W-1:0]   ss_q;
    logic [DATA_W-1:0] tx_sh, rx_sh;
    logic [EW-1:0]     edge_cnt;      // SCLK edges already produced in XFER

    logic tick, sclk_lvl, odd_edge;
    logic start_acc, active, xfer_tick, sample_on_even, sample_now, shift_now;

    assign start_acc = start && (state_q == ST_IDLE);
    assign active    = (state_q == ST_SETUP) || (state_q == ST_XFER) || (state_q == ST_HOLD);
    assign xfer_tick = tick && (state_q == ST_XFER);

    spi_sclk_gen #(.DIV_W(DIV_W)) u_sclk_gen (
        .clk       (clk),
        .rst       (rst),
        .en        (active),
        .toggle_en (state_q == ST_XFER),
        .load      (start_acc),
        .load_lvl  (cpol),
        .div       (div_q),
        .tick      (tick),
        .sclk_lvl  (sclk_lvl),
        .odd_edge  (odd_edge)
    );

    // Modes 1 and 3 sample on even edges; modes 0 and 2 on odd edges.
    always_comb begin
        unique case ({cpol_q, cpha_q})
            MODE1, MODE3: sample_on_even = 1'b1;
            MODE0, MODE2: sample_on_even = 1'b0;
            default:      sample_on_even = 1'b0;
        endcase
    end

    // cpha=1 shifts on odd edges, but the first odd edge still presents the
    // first bit (already on mosi since SETUP); cpha=0 shifts on even edges
    // except the final one.
    assign sample_now = xfer_tick && (sample_on_even ? !odd_edge : odd_edge);
    assign shift_now  = xfer_tick && (sample_on_even ? (odd_edge && edge_cnt != '0)
                                                     : (!odd_edge && edge_cnt != LAST_EDGE));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output of this block gets a default first so no path leaves
    // a variable unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        sclk    = sclk_lvl;
        mosi    = 1'b0;
        ss_n    = '1;

        unique case (state_q)
            ST_IDLE:  if (start) state_d = ST_SETUP;
            ST_SETUP: if (tick) state_d = ST_XFER;
            ST_XFER:  if (tick && edge_cnt == LAST_EDGE) state_d = ST_HOLD;
            ST_HOLD:  if (tick) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        if (state_q == ST_IDLE) begin
            sclk = cpol;
        end else begin
            busy = 1'b1;
        end
        done = (state_q == ST_DONE);

        if (active) begin
            mosi = lsb_q ? tx_sh[0] : tx_sh[DATA_W-1];
            for (int i = 0; i < N_SS; i++) begin
                ss_n[i] = (SS_W'(i) != ss_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
            lsb_q    <= 1'b0;
            div_q    <= '0;
            ss_q     <= '0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            edge_cnt <= '0;
            rx_data  <= '0;
            ntx      <= '0;
        end else begin
            if (start_acc) begin
                cpol_q   <= cpol;
                cpha_q   <= cpha;
                lsb_q    <= lsb_first;
                div_q    <= clk_div;
                ss_q     <= ss_sel;
                tx_sh    <= tx_data;
                rx_sh    <= '0;
                edge_cnt <= '0;
            end
            if (xfer_tick) begin
                edge_cnt <= edge_cnt + 1'b1;
            end
            if (shift_now) begin
                tx_sh <= lsb_q ? (tx_sh >> 1) : (tx_sh << 1);
            end
            if (sample_now) begin
                rx_sh <= lsb_q ? {miso, rx_sh[DATA_W-1:1]} : {rx_sh[DATA_W-2:0], miso};
            end
            if (state_q == ST_HOLD && tick) begin
                rx_data <= rx_sh;
            end
            if (clr_ntx) begin
                ntx <= '0;
            end else if (state_q == ST_DONE) begin
                ntx <= ntx + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_spi_master_gen2.sv
// ----------------------------------------------------------------------------
// tb_spi_master_gen2
//   Self-checking bench: an 8-bit and a 16-bit instance share the control
//   inputs. A cycle-sampled SPI slave model watches the selected instance's
//   bus, records mosi at its sample edges and serves miso from a word.
// ----------------------------------------------------------------------------
module tb_spi_master_gen2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpol = 1'b0, cpha = 1'b0, lsb_first = 1'b0, clr_ntx = 1'b0;
    logic [7:0]  clk_div = 8'd0;
    logic [1:0]  ss_sel = 2'd0;
    logic        start8 = 1'b0, start16 = 1'b0;
    logic [7:0]  tx8 = 8'd0;
    logic [15:0] tx16 = 16'd0;
    logic        miso8, miso16;

    logic [7:0]  rx8, ntx8, ntx16;
    logic [15:0] rx16;
    logic        busy8, done8, sclk8, mosi8, busy16, done16, sclk16, mosi16;
    logic [3:0]  ss8, ss16;

    always #5 clk = ~clk;

    spi_master_gen2 #(.DATA_W(8), .N_SS(4), .DIV_W(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .cpol(cpol), .cpha(cpha),
        .lsb_first(lsb_first), .clk_div(clk_div), .ss_sel(ss_sel),
        .tx_data(tx8), .clr_ntx(clr_ntx), .miso(miso8), .rx_data(rx8),
        .busy(busy8), .done(done8), .ntx(ntx8), .sclk(sclk8), .mosi(mosi8),
        .ss_n(ss8)
    );

    spi_master_gen2 #(.DATA_W(16), .N_SS(4), .DIV_W(8)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .cpol(cpol), .cpha(cpha),
        .lsb_first(lsb_first), .clk_div(clk_div), .ss_sel(ss_sel),
        .tx_data(tx16), .clr_ntx(clr_ntx), .miso(miso16), .rx_data(rx16),
        .busy(busy16), .done(done16), .ntx(ntx16), .sclk(sclk16), .mosi(mosi16),
        .ss_n(ss16)
    );

    // miso source: 0 = slave model, 1 = loopback of mosi, 2 = tied high
    int   miso_mode = 1;
    logic slave_bit = 1'b0;
    assign miso8  = (miso_mode == 1) ? mosi8  : (miso_mode == 2) ? 1'b1 : slave_bit;
    assign miso16 = (miso_mode == 1) ? mosi16 : (miso_mode == 2) ? 1'b1 : slave_bit;

    bit         sel16 = 1'b0;
    logic       m_sclk, m_mosi, m_busy, m_done;
    logic [3:0] m_ss;
    assign m_sclk = sel16 ? sclk16 : sclk8;
    assign m_mosi = sel16 ? mosi16 : mosi8;
    assign m_busy = sel16 ? busy16 : busy8;
    assign m_done = sel16 ? done16 : done8;
    assign m_ss   = sel16 ? ss16   : ss8;

    int checks = 0;
    int errors = 0;

    // Transfer parameters as the slave model sees them, and observed stats.
    logic [31:0] slave_word = 0;
    int          dw_t = 8;
    logic        cpha_t = 0, lsb_t = 0;
    logic [1:0]  ss_t = 0;
    int  busy_cycles, done_cnt, done_run, done_run_max, rises, ss_err, idle_err;
    int  edge_k, slave_idx;
    bit  mosi_q[$];
    logic prev_sclk, prev_active, mon_act;
    logic [3:0] mon_exp_ss;
    int  ntx8_m = 0, ntx16_m = 0;

    function automatic logic bit_at(logic [31:0] w, int k, int dw, logic lsb);
        return lsb ? w[k] : w[dw-1-k];
    endfunction

    // Bits in transmission order, first bit ends up most significant.
    function automatic logic [31:0] order_word(logic [31:0] w, int dw, logic lsb);
        logic [31:0] r = 0;
        for (int k = 0; k < dw; k++) r = {r[30:0], bit_at(w, k, dw, lsb)};
        return r;
    endfunction

    function automatic logic [31:0] got_seq();
        logic [31:0] r = 0;
        foreach (mosi_q[i]) r = {r[30:0], mosi_q[i]};
        return r;
    endfunction

    function automatic int exp_busy(int dv, int dw);
        return (dv + 1) * (2 * dw + 2) + 1;
    endfunction

    always @(negedge clk) begin
        mon_act = (m_ss != 4'hF);
        if (m_busy) busy_cycles++;
        if (m_done) begin
            done_cnt++;
            done_run++;
            if (done_run > done_run_max) done_run_max = done_run;
        end else begin
            done_run = 0;
        end
        mon_exp_ss = (m_busy && !m_done) ? ~(4'b0001 << ss_t) : 4'hF;
        if (m_ss !== mon_exp_ss) ss_err++;
        if (!m_busy && m_sclk !== cpol) idle_err++;
        if (m_sclk === 1'b1 && prev_sclk === 1'b0) rises++;
        if (mon_act && !prev_active) begin
            edge_k    = 0;
            slave_idx = 0;
            if (!cpha_t) slave_bit = bit_at(slave_word, 0, dw_t, lsb_t);
        end else if (mon_act && m_sclk !== prev_sclk) begin
            edge_k++;
            if (((edge_k % 2) == 1) != cpha_t) begin
                mosi_q.push_back(m_mosi);
            end else begin
                if (!cpha_t) slave_idx++;
                if (slave_idx < dw_t) slave_bit = bit_at(slave_word, slave_idx, dw_t, lsb_t);
                if (cpha_t) slave_idx++;
            end
        end
        prev_sclk   = m_sclk;
        prev_active = mon_act;
    end

    task automatic clear_stats();
        busy_cycles = 0; done_cnt = 0; done_run = 0; done_run_max = 0;
        rises = 0; ss_err = 0; idle_err = 0; edge_k = 0; slave_idx = 0;
        mosi_q.delete();
        prev_sclk = m_sclk;
        prev_active = 1'b0;
    endtask

    task automatic do_xfer(input bit is16, input logic cp, input logic ch, input logic lsb,
                           input logic [7:0] dv, input logic [1:0] ss, input logic [31:0] tx,
                           input int mmode, input logic [31:0] sw, input int restart_cyc,
                           input bit clr_at_done, output bit timed_out);
        int bound;
        @(posedge clk); #1;
        sel16 = is16; cpol = cp; cpha = ch; lsb_first = lsb; clk_div = dv; ss_sel = ss;
        tx8 = tx[7:0]; tx16 = tx[15:0]; miso_mode = mmode; slave_word = sw;
        dw_t = is16 ? 16 : 8; cpha_t = ch; lsb_t = lsb; ss_t = ss;
        #1;
        clear_stats();
        if (is16) start16 = 1'b1; else start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0; start16 = 1'b0;
        // Latched inputs are don't-care from here on.
        tx8 = 8'($urandom); tx16 = 16'($urandom); clk_div = 8'($urandom);
        lsb_first = 1'($urandom); ss_sel = 2'($urandom);
        bound = exp_busy(int'(dv), dw_t) + 5;
        timed_out = 1'b1;
        for (int c = 1; c <= bound; c++) begin
            @(posedge clk); #1;
            if (is16) start16 = (c == restart_cyc); else start8 = (c == restart_cyc);
            clr_ntx = clr_at_done && m_done;
            if (!m_busy) begin
                timed_out = 1'b0;
                break;
            end
        end
        start8 = 1'b0; start16 = 1'b0; clr_ntx = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; cpol = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (ss8 !== 4'hF) begin errors++; $display("FAIL reset_ss8 got %b want 1111", ss8); end
        checks++; if (ss16 !== 4'hF) begin errors++; $display("FAIL reset_ss16 got %b want 1111", ss16); end
        checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy8); end
        checks++; if (done8 !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done8); end
        checks++; if (sclk8 !== 1'b0) begin errors++; $display("FAIL reset_sclk got %b want 0", sclk8); end
        checks++; if (mosi8 !== 1'b0) begin errors++; $display("FAIL reset_mosi got %b want 0", mosi8); end
        checks++; if (rx8 !== 8'h00) begin errors++; $display("FAIL reset_rx got %h want 00", rx8); end
        checks++; if (ntx8 !== 8'h00) begin errors++; $display("FAIL reset_ntx got %0d want 0", ntx8); end
        rst = 1'b0;
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        sel16 = 1'b0; cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0; clk_div = 8'd0;
        ss_sel = 2'd1; ss_t = 2'd1; tx8 = 8'hC3; miso_mode = 1; cpha_t = 1'b0; dw_t = 8;
        #1;
        clear_stats();
        start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy8); end
        checks++; if (ss8 !== 4'hF) begin errors++; $display("FAIL abort_ss got %b want 1111", ss8); end
        checks++; if (rx8 !== 8'h00) begin errors++; $display("FAIL abort_rx got %h want 00", rx8); end
        rst = 1'b0;
        repeat (25) @(posedge clk);
        #1;
        checks++; if (done_cnt !== 0) begin errors++; $display("FAIL abort_done got %0d want 0", done_cnt); end
        checks++; if (ntx8 !== 8'd0) begin errors++; $display("FAIL abort_ntx got %0d want 0", ntx8); end
        checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL abort_idle got %b want 0", busy8); end
    endtask

    task automatic test_mode0_loop();
        bit to;
        do_xfer(0, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0, 32'hA5, 1, 0, 0, 0, to);
        ntx8_m = (ntx8_m + 1) % 256;
        checks++; if (to) begin errors++; $display("FAIL m0_timeout got 1 want 0"); end
        checks++; if (rx8 !== 8'hA5) begin errors++; $display("FAIL m0_rx got %h want a5", rx8); end
        checks++; if (rises !== 8) begin errors++; $display("FAIL m0_rises got %0d want 8", rises); end
        checks++; if (busy_cycles !== 19) begin errors++; $display("FAIL m0_busy got %0d want 19", busy_cycles); end
        checks++; if (ntx8 !== 8'(ntx8_m)) begin errors++; $display("FAIL m0_ntx got %0d want %0d", ntx8, ntx8_m); end
        checks++; if (got_seq() !== order_word(32'hA5, 8, 1'b0)) begin errors++; $display("FAIL m0_mosi got %h want %h", got_seq(), order_word(32'hA5, 8, 1'b0)); end
    endtask

    task automatic test_mode3_lsb();
        bit to;
        do_xfer(0, 1'b1, 1'b1, 1'b1, 8'd3, 2'd1, 32'h3C, 2, 0, 0, 0, to);
        ntx8_m = (ntx8_m + 1) % 256;
        checks++; if (to) begin errors++; $display("FAIL m3_timeout got 1 want 0"); end
        checks++; if (rx8 !== 8'hFF) begin errors++; $display("FAIL m3_rx got %h want ff", rx8); end
        checks++; if (got_seq() !== 32'b00111100) begin errors++; $display("FAIL m3_mosi got %b want 00111100", got_seq()); end
        checks++; if (mosi_q.size() !== 8) begin errors++; $display("FAIL m3_nbits got %0d want 8", mosi_q.size()); end
        checks++; if (idle_err !== 0) begin errors++; $display("FAIL m3_idle_sclk got %0d want 0", idle_err); end
        checks++; if (busy_cycles !== 73) begin errors++; $display("FAIL m3_busy got %0d want 73", busy_cycles); end
        checks++; if (rises !== 8) begin errors++; $display("FAIL m3_rises got %0d want 8", rises); end
    endtask

    task automatic test_ss_restart();
        bit to;
        do_xfer(0, 1'b0, 1'b0, 1'b0, 8'd0, 2'd2, 32'h5E, 1, 0, 7, 0, to);
        ntx8_m = (ntx8_m + 1) % 256;
        checks++; if (ss_err !== 0) begin errors++; $display("FAIL ss_pattern got %0d bad cycles want 0", ss_err); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL restart_done got %0d want 1", done_cnt); end
        checks++; if (busy_cycles !== 19) begin errors++; $display("FAIL restart_busy got %0d want 19", busy_cycles); end
        checks++; if (rx8 !== 8'h5E) begin errors++; $display("FAIL restart_rx got %h want 5e", rx8); end
        checks++; if (ntx8 !== 8'(ntx8_m)) begin errors++; $display("FAIL restart_ntx got %0d want %0d", ntx8, ntx8_m); end
    endtask

    task automatic test_mode1_16();
        bit to;
        logic [31:0] tx;
        tx = {16'h0, 16'($urandom)};
        do_xfer(1, 1'b0, 1'b1, 1'b0, 8'd1, 2'd3, tx, 0, 32'hBEEF, 0, 0, to);
        ntx16_m = (ntx16_m + 1) % 256;
        checks++; if (to) begin errors++; $display("FAIL m1_timeout got 1 want 0"); end
        checks++; if (rx16 !== 16'hBEEF) begin errors++; $display("FAIL m1_rx got %h want beef", rx16); end
        checks++; if (done_run_max !== 1 || done_cnt !== 1) begin errors++; $display("FAIL m1_done got width %0d count %0d want 1 1", done_run_max, done_cnt); end
        checks++; if (busy_cycles !== exp_busy(1, 16)) begin errors++; $display("FAIL m1_busy got %0d want %0d", busy_cycles, exp_busy(1, 16)); end
        checks++; if (got_seq() !== order_word(tx, 16, 1'b0)) begin errors++; $display("FAIL m1_mosi got %h want %h", got_seq(), order_word(tx, 16, 1'b0)); end
        checks++; if (ntx16 !== 8'(ntx16_m)) begin errors++; $display("FAIL m1_ntx got %0d want %0d", ntx16, ntx16_m); end
    endtask

    task automatic test_random();
        bit to, is16, cp, ch, lsb;
        logic [7:0] dv;
        logic [1:0] ss;
        logic [31:0] tx, sw, mask, exp_rx, got_rx;
        int mm, dw;
        for (int n = 0; n < 16; n++) begin
            is16 = 1'($urandom); cp = 1'($urandom); ch = 1'($urandom); lsb = 1'($urandom);
            dv = 8'($urandom_range(0, 3)); ss = 2'($urandom); mm = $urandom_range(0, 2);
            tx = $urandom; sw = $urandom;
            dw = is16 ? 16 : 8;
            mask = is16 ? 32'hFFFF : 32'hFF;
            exp_rx = (mm == 1) ? (tx & mask) : (mm == 2) ? mask : (sw & mask);
            do_xfer(is16, cp, ch, lsb, dv, ss, tx & mask, mm, sw & mask, 0, 0, to);
            if (is16) ntx16_m = (ntx16_m + 1) % 256; else ntx8_m = (ntx8_m + 1) % 256;
            got_rx = is16 ? {16'h0, rx16} : {24'h0, rx8};
            checks++; if (to) begin errors++; $display("FAIL rnd%0d_timeout got 1 want 0", n); end
            checks++; if (got_rx !== exp_rx) begin errors++; $display("FAIL rnd%0d_rx got %h want %h (mode %0d%0d lsb %0d div %0d)", n, got_rx, exp_rx, cp, ch, lsb, dv); end
            checks++; if (got_seq() !== order_word(tx & mask, dw, lsb)) begin errors++; $display("FAIL rnd%0d_mosi got %h want %h", n, got_seq(), order_word(tx & mask, dw, lsb)); end
            checks++; if (busy_cycles !== exp_busy(int'(dv), dw)) begin errors++; $display("FAIL rnd%0d_busy got %0d want %0d", n, busy_cycles, exp_busy(int'(dv), dw)); end
            checks++; if (done_cnt !== 1 || ss_err !== 0 || idle_err !== 0) begin errors++; $display("FAIL rnd%0d_bus got done %0d ss_err %0d idle_err %0d want 1 0 0", n, done_cnt, ss_err, idle_err); end
            checks++; if ((is16 ? ntx16 : ntx8) !== 8'(is16 ? ntx16_m : ntx8_m)) begin errors++; $display("FAIL rnd%0d_ntx got %0d want %0d", n, is16 ? ntx16 : ntx8, is16 ? ntx16_m : ntx8_m); end
        end
    endtask

    task automatic test_ntx_wrap();
        bit to;
        while (ntx8_m != 255) begin
            do_xfer(0, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0, 32'h11, 1, 0, 0, 0, to);
            ntx8_m++;
            if (to) break;
        end
        checks++; if (ntx8 !== 8'd255) begin errors++; $display("FAIL wrap_pre got %0d want 255", ntx8); end
        do_xfer(0, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0, 32'h22, 1, 0, 0, 0, to);
        ntx8_m = (ntx8_m + 1) % 256;
        checks++; if (ntx8 !== 8'(ntx8_m)) begin errors++; $display("FAIL wrap_post got %0d want %0d", ntx8, ntx8_m); end
    endtask

    task automatic test_clr_ntx();
        bit to;
        do_xfer(0, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0, 32'h33, 1, 0, 0, 0, to);
        ntx8_m = (ntx8_m + 1) % 256;
        checks++; if (ntx8 !== 8'(ntx8_m)) begin errors++; $display("FAIL clr_pre got %0d want %0d", ntx8, ntx8_m); end
        do_xfer(0, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0, 32'h44, 1, 0, 0, 1, to);
        ntx8_m = 0; ntx16_m = 0;
        checks++; if (ntx8 !== 8'd0) begin errors++; $display("FAIL clr_in_done got %0d want 0", ntx8); end
        do_xfer(0, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0, 32'h55, 1, 0, 0, 0, to);
        checks++; if (ntx8 !== 8'd1) begin errors++; $display("FAIL clr_recount got %0d want 1", ntx8); end
        clr_ntx = 1'b1;
        @(posedge clk); #1;
        clr_ntx = 1'b0;
        checks++; if (ntx8 !== 8'd0 || ntx16 !== 8'd0) begin errors++; $display("FAIL clr_idle got %0d %0d want 0 0", ntx8, ntx16); end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_reset_mid();
        test_mode0_loop();
        test_mode3_lsb();
        test_ss_restart();
        test_mode1_16();
        test_random();
        test_ntx_wrap();
        test_clr_ntx();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
